// File: rtl/pipeline_ctrl.sv
// Pipeline hazard / stall / flush controller for a 5-stage in-order core.
// Ports:
//   clk, rst           - clock, synchronous active-low reset
//   id_rs1/id_rs2      - ID source registers, id_use_rs1/id_use_rs2 qualify them
//   ex_rd, ex_memread  - EX destination register and load flag
//   ex_branch, ex_mispredict - branch resolved in EX, prediction wrong
//   imem_ready         - instruction fetch data valid
//   mem_access, dmem_ready - MEM access pending / completing
//   pc_en .. memwb_en  - load enables for the PC and pipeline registers
//   ifid_flush, idex_flush - load a bubble when the register is enabled
//   stall_cnt, flush_cnt   - performance counters
//   timeout_err        - sticky data-memory wait timeout flag
module pipeline_ctrl #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch,
  input  logic             ex_mispredict,
  input  logic             imem_ready,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             timeout_err
);

  // Wide enough to hold TIMEOUT-1 plus one more count.
  localparam int unsigned WAIT_W = $clog2(TIMEOUT) + 1;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_REDIRECT = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              freeze;
  logic              mispredict;
  logic              load_use;
  logic              stall_inc;
  logic              flush_inc;

  // Hazard detection; x0 is hardwired zero so it never creates a dependency.
  always_comb begin
    freeze     = mem_access & ~dmem_ready;
    mispredict = ex_branch & ex_mispredict;
    load_use   = ex_memread && (ex_rd != 5'd0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                  (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  // Prioritised enable/flush decode and next state.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_nxt  = state;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    if (!rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_nxt  = ST_RUN;
    end else if (freeze) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      memwb_en  = 1'b0;
      stall_inc = 1'b1;
    end else if (mispredict) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_inc  = 1'b1;
      state_nxt  = imem_ready ? ST_RUN : ST_REDIRECT;
    end else if (state == ST_REDIRECT) begin
      // Hold the PC on the redirect target until fetch delivers it.
      pc_en      = imem_ready;
      ifid_flush = 1'b1;
      if (imem_ready) state_nxt = ST_RUN;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      stall_inc  = 1'b1;
    end else if (!imem_ready) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
      stall_inc  = 1'b1;
    end
  end

  // State, counters and timeout tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_RUN;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (stall_inc) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc) flush_cnt <= flush_cnt + CNT_W'(1);
      if (freeze) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
        if (wait_cnt == WAIT_W'(TIMEOUT - 1)) timeout_err <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios then random traffic,
// every cycle compared against a priority-rule reference model.
module tb_pipeline_ctrl;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CMASK   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_memread;
  logic             ex_branch, ex_mispredict, imem_ready, mem_access, dmem_ready;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, timeout_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread),
    .ex_branch(ex_branch), .ex_mispredict(ex_mispredict),
    .imem_ready(imem_ready), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .timeout_err(timeout_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: redirect pending, counters, wait run length.
  bit          m_redir = 1'b0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;
  int unsigned m_wait  = 0;
  bit          m_terr  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0;
    ex_branch = 1'b0; ex_mispredict = 1'b0; imem_ready = 1'b1;
    mem_access = 1'b0; dmem_ready = 1'b1;
  endtask

  // Output vector order: {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}.
  task automatic tick();
    logic [6:0] e;
    bit fz, mp, lu;
    #1;
    fz = mem_access && !dmem_ready;
    mp = ex_branch && ex_mispredict;
    lu = ex_memread && (ex_rd != 5'd0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (!rst)               e = 7'b0000011;
    else if (fz)            e = 7'b0000000;
    else if (mp)            e = 7'b1111111;
    else if (m_redir)       e = {imem_ready, 6'b111110};
    else if (lu)            e = 7'b0011101;
    else if (!imem_ready)   e = 7'b0111110;
    else                    e = 7'b1111100;
    chk("outputs", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}), 32'(e));
    chk("stall_cnt", 32'(stall_cnt), m_stall);
    chk("flush_cnt", 32'(flush_cnt), m_flush);
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    if (!rst) begin
      m_redir = 1'b0; m_stall = 0; m_flush = 0; m_wait = 0; m_terr = 1'b0;
    end else if (fz) begin
      m_stall = (m_stall + 1) & CMASK;
      m_wait++;
      if (m_wait >= TIMEOUT) m_terr = 1'b1;
    end else begin
      m_wait = 0;
      if (mp) begin
        m_flush = (m_flush + 1) & CMASK;
        m_redir = !imem_ready;
      end else if (m_redir) begin
        if (imem_ready) m_redir = 1'b0;
      end else if (lu || !imem_ready) begin
        m_stall = (m_stall + 1) & CMASK;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Reset with noisy inputs: outputs forced, counters cleared.
    ex_branch = 1'b1; ex_mispredict = 1'b1; mem_access = 1'b1; dmem_ready = 1'b0;
    tick();
    tick();
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);

    idle(); tick();

    // Load-use on rs1.
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    tick();
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    // Same with x0 destination: no stall.
    ex_rd = 5'd0; id_rs1 = 5'd0;
    tick();
    chk("x0_stall_cnt", 32'(stall_cnt), 32'd1);

    // Mispredict during a fetch wait, two REDIRECT wait cycles, then fetch returns.
    idle(); ex_branch = 1'b1; ex_mispredict = 1'b1; imem_ready = 1'b0;
    tick();
    idle(); imem_ready = 1'b0;
    tick();
    chk("redir_pc_hold", 32'(pc_en), 32'd0);
    tick();
    imem_ready = 1'b1;
    tick();
    chk("redir_flush_cnt", 32'(flush_cnt), 32'd1);
    tick();
    chk("redir_back_run", 32'(ifid_flush), 32'd0);

    // Freeze outranks a mispredict; mispredict applies once memory completes.
    idle(); ex_branch = 1'b1; ex_mispredict = 1'b1; mem_access = 1'b1; dmem_ready = 1'b0;
    tick();
    tick();
    chk("frz_flush_cnt", 32'(flush_cnt), 32'd1);
    dmem_ready = 1'b1;
    tick();
    chk("frz_then_mp", 32'(flush_cnt), 32'd2);

    // Four-cycle data-memory wait trips the timeout at the end of the 4th.
    idle(); mem_access = 1'b1; dmem_ready = 1'b0;
    tick(); tick(); tick();
    chk("to_not_yet", 32'(timeout_err), 32'd0);
    tick();
    chk("to_set", 32'(timeout_err), 32'd1);
    dmem_ready = 1'b1;
    tick();
    idle(); tick();
    chk("to_sticky", 32'(timeout_err), 32'd1);

    // Reset in the middle of REDIRECT.
    idle(); ex_branch = 1'b1; ex_mispredict = 1'b1; imem_ready = 1'b0;
    tick();
    idle(); imem_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_mid_flush", 32'(flush_cnt), 32'd0);
    chk("rst_mid_stall", 32'(stall_cnt), 32'd0);
    chk("rst_mid_terr", 32'(timeout_err), 32'd0);
    idle();
    tick();
    chk("rst_mid_run", 32'(ifid_flush), 32'd0);

    // Random traffic with small register ranges to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom % 1000) != 0;
      id_rs1        = 5'($urandom % 4);
      id_rs2        = 5'($urandom % 4);
      ex_rd         = 5'($urandom % 4);
      id_use_rs1    = 1'($urandom);
      id_use_rs2    = 1'($urandom);
      ex_memread    = 1'($urandom);
      ex_branch     = ($urandom % 4) == 0;
      ex_mispredict = 1'($urandom);
      imem_ready    = ($urandom % 4) != 0;
      mem_access    = ($urandom % 3) == 0;
      dmem_ready    = ($urandom % 4) != 0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
